// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator and the ECC blocks that reuse
// its XOR-reduction helper.
package parity_pkg;

    localparam int PARITY_WIDTH_DEFAULT = 8;
    localparam int PARITY_WIDTH_MAX     = 64;

    // Reference XOR reduction over the low `width` bits of `data`.
    function automatic logic xor_reduce(
        input logic [PARITY_WIDTH_MAX-1:0] data,
        input int unsigned                 width
    );
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < PARITY_WIDTH_MAX; i++) begin
            if (i < int'(width)) begin
                acc = acc ^ data[i];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/parity_gen_xor_tree.sv
// Balanced binary XOR tree: reduces WIDTH bits to one bit in ceil(log2(WIDTH))
// levels. Leaves beyond WIDTH are tied to zero so they do not change the result.
module xor_tree
    import parity_pkg::*;
#(
    parameter int WIDTH = PARITY_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] din,
    output logic             parity
);

    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int LEAVES = 1 << LEVELS;

    // Level l holds 2**l partial results; level LEVELS is the padded input.
    for (genvar l = 0; l <= LEVELS; l++) begin : lv
        logic [(1<<l)-1:0] bits;
        if (l == LEVELS) begin : leaf
            for (genvar k = 0; k < LEAVES; k++) begin : leaf_bit
                if (k < WIDTH) begin : used
                    assign bits[k] = din[k];
                end else begin : pad
                    assign bits[k] = 1'b0;
                end
            end
        end else begin : inner
            for (genvar k = 0; k < (1 << l); k++) begin : node
                assign bits[k] = lv[l+1].bits[2*k] ^ lv[l+1].bits[2*k+1];
            end
        end
    end

    assign parity = lv[0].bits[0];

endmodule

// File: rtl/parity_gen.sv
// Even-parity generator with a combinational output and a registered copy
// (plus valid flag) for pipelined consumers.
module parity_gen
    import parity_pkg::*;
#(
    parameter int WIDTH = PARITY_WIDTH_DEFAULT,
    parameter bit ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             parity,
    output logic             parity_odd,
    output logic             parity_q,
    output logic             parity_q_valid
);

    xor_tree #(
        .WIDTH(WIDTH)
    ) u_xor_tree (
        .din   (din),
        .parity(parity)
    );

    if (ODD) begin : g_odd_follow
        assign parity_odd = parity;
    end else begin : g_odd_invert
        assign parity_odd = ~parity;
    end

    // parity_q holds the last valid sample; reset discards it outright.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            parity_q       <= 1'b0;
            parity_q_valid <= 1'b0;
        end else begin
            parity_q_valid <= din_valid;
            if (din_valid) begin
                parity_q <= parity;
            end
        end
    end

endmodule

// File: tb/tb_parity_gen.sv
// Self-checking bench for parity_gen: scoreboard of expected bits, directed
// and random bytes on both clock edges, registered path and async reset.
module tb_parity_gen;

    logic        clk       = 1'b0;
    logic        areset    = 1'b0;
    logic [7:0]  din       = '0;
    logic        din_valid = 1'b0;
    logic [63:0] din64     = '0;
    logic [0:0]  din1      = '0;

    logic parity, parity_odd, parity_q, parity_q_valid;
    logic odd_parity, odd_parity_odd, odd_parity_q, odd_parity_q_valid;
    logic w64_parity, w64_parity_odd, w64_parity_q, w64_parity_q_valid;
    logic w1_parity, w1_parity_odd, w1_parity_q, w1_parity_q_valid;

    always #5 clk = ~clk;

    parity_gen u_dut (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid),
        .parity(parity), .parity_odd(parity_odd),
        .parity_q(parity_q), .parity_q_valid(parity_q_valid)
    );

    parity_gen #(.WIDTH(8), .ODD(1'b1)) u_odd (
        .clk(clk), .areset(areset), .din(din), .din_valid(din_valid),
        .parity(odd_parity), .parity_odd(odd_parity_odd),
        .parity_q(odd_parity_q), .parity_q_valid(odd_parity_q_valid)
    );

    parity_gen #(.WIDTH(64)) u_w64 (
        .clk(clk), .areset(areset), .din(din64), .din_valid(din_valid),
        .parity(w64_parity), .parity_odd(w64_parity_odd),
        .parity_q(w64_parity_q), .parity_q_valid(w64_parity_q_valid)
    );

    parity_gen #(.WIDTH(1)) u_w1 (
        .clk(clk), .areset(areset), .din(din1), .din_valid(din_valid),
        .parity(w1_parity), .parity_odd(w1_parity_odd),
        .parity_q(w1_parity_q), .parity_q_valid(w1_parity_q_valid)
    );

    typedef struct {
        string tag;
        logic  exp;
    } exp_t;

    exp_t       sb[$];
    int         tests_run = 0;
    int         failures  = 0;
    logic       model_q   = 1'b0;
    logic [7:0] directed [6];

    function automatic logic model_parity(input logic [63:0] d);
        return ($countones(d) % 2) == 1;
    endfunction

    task automatic expectBit(input string tag, input logic e);
        exp_t item;
        item.tag = tag;
        item.exp = e;
        sb.push_back(item);
    endtask

    task automatic checkOutput(input logic obs);
        exp_t item;
        tests_run++;
        if (sb.size() == 0) begin
            failures++;
            $error("[TB] FAIL scoreboard_empty: observed %b, no expected entry", obs);
        end else begin
            item = sb.pop_front();
            assert (obs === item.exp) else begin
                failures++;
                $error("[TB] FAIL %s: observed %b expected %b", item.tag, obs, item.exp);
            end
        end
    endtask

    // Drive one byte and queue what every observed output should show for it.
    task automatic applyStimulus(input logic [7:0] d, input logic v, input bit track_reg);
        din       = d;
        din_valid = v;
        expectBit("parity", model_parity(64'(d)));
        expectBit("parity_odd", ~model_parity(64'(d)));
        expectBit("odd_parity_odd", model_parity(64'(d)));
        if (track_reg) begin
            if (v) model_q = model_parity(64'(d));
            expectBit("parity_q", model_q);
            expectBit("parity_q_valid", v);
        end
    endtask

    task automatic checkComb();
        #1;
        checkOutput(parity);
        checkOutput(parity_odd);
        checkOutput(odd_parity_odd);
    endtask

    task automatic stepComb(input logic [7:0] d);
        @(clk);
        #1;
        applyStimulus(d, 1'b0, 1'b0);
        checkComb();
    endtask

    task automatic stepReg(input logic [7:0] d, input logic v);
        @(negedge clk);
        #1;
        applyStimulus(d, v, 1'b1);
        checkComb();
        @(posedge clk);
        #1;
        checkOutput(parity_q);
        checkOutput(parity_q_valid);
    endtask

    task automatic checkWide(input logic [63:0] d64, input logic d1);
        din64   = d64;
        din1[0] = d1;
        expectBit("w64_parity", model_parity(d64));
        expectBit("w1_parity", d1);
        #1;
        checkOutput(w64_parity);
        checkOutput(w1_parity);
    endtask

    initial begin
        directed = '{8'h00, 8'h01, 8'hFF, 8'h7F, 8'hA5, 8'h80};

        #1 areset = 1'b1;
        #1;
        expectBit("reset_parity_q", 1'b0);
        expectBit("reset_parity_q_valid", 1'b0);
        checkOutput(parity_q);
        checkOutput(parity_q_valid);
        applyStimulus(8'h01, 1'b0, 1'b0);
        checkComb();

        @(negedge clk);
        areset = 1'b0;

        for (int rep = 0; rep < 2; rep++) begin
            if (rep == 1) @(clk);
            foreach (directed[i]) stepComb(directed[i]);
        end

        repeat (100) stepComb(8'($urandom_range(0, 255)));

        checkWide(64'h8000_0000_0000_0001, 1'b1);
        checkWide(64'h0000_0000_0000_0001, 1'b0);
        checkWide(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        repeat (20) checkWide({$urandom, $urandom}, 1'($urandom));

        stepReg(8'h03, 1'b1);
        stepReg(8'h07, 1'b1);
        stepReg(8'h0F, 1'b0);

        @(negedge clk);
        #2;
        areset  = 1'b1;
        model_q = 1'b0;
        #1;
        expectBit("async_reset_parity_q", 1'b0);
        expectBit("async_reset_parity_q_valid", 1'b0);
        checkOutput(parity_q);
        checkOutput(parity_q_valid);
        applyStimulus(8'h7F, 1'b1, 1'b0);
        checkComb();
        @(posedge clk);
        #1;
        expectBit("held_reset_parity_q", 1'b0);
        expectBit("held_reset_parity_q_valid", 1'b0);
        checkOutput(parity_q);
        checkOutput(parity_q_valid);
        @(negedge clk);
        areset = 1'b0;

        stepReg(8'h01, 1'b1);
        stepReg(8'h00, 1'b0);

        tests_run++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("[TB] FAIL scoreboard_drain: observed %0d entries, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
